pipeline_control: RTL and testbench

Sequential pipeline sequencer for the 5-stage RV32I core. It consumes the stall and flush requests produced by hazard detection, the EX-stage branch redirect, and the instruction/data memory ready handshakes. It applies them as per-stage register enables and valid bits. It also owns the drain/halt state machine and saturating stall/flush performance counters. It sits between the hazard unit and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipeline_control.sv | 160 ++++++++++++++++
 tb/tb_pipeline_control.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Pipeline sequencer for the 5-stage RV32I core: turns hazard/redirect/memory
// handshakes into per-stage enables and valid bits, and owns the drain/halt FSM.
module pipeline_control #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_if_req,
   input  logic                 stall_id_req,
   input  logic                 flush_ex_req,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   input  logic                 imem_ready,
   input  logic                 dmem_req,
   input  logic                 dmem_ready,
   input  logic                 halt_req,
   output logic                 pc_en,
   output logic                 if_id_en,
   output logic                 id_ex_en,
   output logic                 ex_mem_en,
   output logic                 mem_wb_en,
   output logic                 if_id_valid,
   output logic                 id_ex_valid,
   output logic                 ex_mem_valid,
   output logic                 mem_wb_valid,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_count
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_DRAIN    = 2'd2,
      S_HALTED   = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 ret_drain_q, ret_drain_d;
   logic                 if_id_q, if_id_d;
   logic                 id_ex_q, id_ex_d;
   logic                 ex_mem_q, ex_mem_d;
   logic                 mem_wb_q, mem_wb_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [CNT_WIDTH-1:0] flush_cnt_q;
   logic                 stall_inc, flush_inc;
   logic                 mem_wait, redirect_req, load_use, drain_mode;

   assign mem_wait     = ex_mem_q & dmem_req & ~dmem_ready;
   assign redirect_req = branch_taken & id_ex_q & ~mem_wait;
   assign load_use     = (stall_if_req | stall_id_req) & ~redirect_req & ~mem_wait;
   // MEM_WAIT remembers whether it interrupted RUN or DRAIN
   assign drain_mode   = (state_q == S_DRAIN) || ((state_q == S_MEM_WAIT) && ret_drain_q);

   // Next-state, valid bits and combinational enables
   always_comb begin
      state_d        = state_q;
      ret_drain_d    = ret_drain_q;
      if_id_d        = if_id_q;
      id_ex_d        = id_ex_q;
      ex_mem_d       = ex_mem_q;
      mem_wb_d       = mem_wb_q;
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      id_ex_en       = 1'b0;
      ex_mem_en      = 1'b0;
      mem_wb_en      = 1'b0;
      redirect_valid = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;

      if (!rst && (state_q != S_HALTED)) begin
         if (mem_wait) begin
            mem_wb_en   = 1'b1;
            mem_wb_d    = 1'b0;
            state_d     = S_MEM_WAIT;
            ret_drain_d = drain_mode;
         end else if (redirect_req) begin
            pc_en          = ~drain_mode;
            redirect_valid = ~drain_mode;
            if_id_en       = 1'b1;
            id_ex_en       = 1'b1;
            ex_mem_en      = 1'b1;
            mem_wb_en      = 1'b1;
            if_id_d        = 1'b0;
            id_ex_d        = 1'b0;
            ex_mem_d       = id_ex_q;
            mem_wb_d       = ex_mem_q;
         end else if (load_use) begin
            id_ex_en  = flush_ex_req;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (flush_ex_req) id_ex_d = 1'b0;
            ex_mem_d  = id_ex_q;
            mem_wb_d  = ex_mem_q;
         end else begin
            pc_en     = imem_ready;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if_id_d   = imem_ready;
            id_ex_d   = if_id_q;
            ex_mem_d  = id_ex_q;
            mem_wb_d  = ex_mem_q;
         end

         if (drain_mode) begin
            pc_en   = 1'b0;
            if_id_d = 1'b0;
         end

         // Halt once the next-cycle pipeline is empty
         if (!mem_wait) begin
            if (drain_mode) begin
               state_d = (!id_ex_d && !ex_mem_d && !mem_wb_d) ? S_HALTED : S_DRAIN;
            end else begin
               state_d = halt_req ? S_DRAIN : S_RUN;
            end
         end

         stall_inc = ~pc_en;
         flush_inc = redirect_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         ret_drain_q <= 1'b0;
         if_id_q     <= 1'b0;
         id_ex_q     <= 1'b0;
         ex_mem_q    <= 1'b0;
         mem_wb_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_drain_q <= ret_drain_d;
         if_id_q     <= if_id_d;
         id_ex_q     <= id_ex_d;
         ex_mem_q    <= ex_mem_d;
         mem_wb_q    <= mem_wb_d;
         if (stall_inc && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         if (flush_inc && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign if_id_valid  = if_id_q;
   assign id_ex_valid  = id_ex_q;
   assign ex_mem_valid = ex_mem_q;
   assign mem_wb_valid = mem_wb_q;
   assign redirect_pc  = branch_target;
   assign halted       = (state_q == S_HALTED) & ~rst;
   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: reset, stalls, redirects, memory wait,
// drain/halt and counter saturation (second instance with 4-bit counters).
module tb_pipeline_control;

   logic        clk = 1'b0;
   logic        rst, stall_if_req, stall_id_req, flush_ex_req, branch_taken;
   logic [31:0] branch_target;
   logic        imem_ready, dmem_req, dmem_ready, halt_req;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid;
   logic        redirect_valid, halted;
   logic [31:0] redirect_pc, stall_cycles, flush_count;

   logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
   logic        s_if_id_valid, s_id_ex_valid, s_ex_mem_valid, s_mem_wb_valid;
   logic        s_redirect_valid, s_halted;
   logic [31:0] s_redirect_pc;
   logic [3:0]  s_stall_cycles, s_flush_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_control #(.CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .stall_if_req(stall_if_req), .stall_id_req(stall_id_req),
      .flush_ex_req(flush_ex_req), .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_valid(if_id_valid), .id_ex_valid(id_ex_valid),
      .ex_mem_valid(ex_mem_valid), .mem_wb_valid(mem_wb_valid), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halted(halted), .stall_cycles(stall_cycles),
      .flush_count(flush_count));

   pipeline_control #(.CNT_WIDTH(4)) dut_small (
      .clk(clk), .rst(rst), .stall_if_req(stall_if_req), .stall_id_req(stall_id_req),
      .flush_ex_req(flush_ex_req), .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
      .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
      .mem_wb_en(s_mem_wb_en), .if_id_valid(s_if_id_valid), .id_ex_valid(s_id_ex_valid),
      .ex_mem_valid(s_ex_mem_valid), .mem_wb_valid(s_mem_wb_valid),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .halted(s_halted),
      .stall_cycles(s_stall_cycles), .flush_count(s_flush_count));

   task automatic idle_inputs();
      stall_if_req  = 1'b0;
      stall_id_req  = 1'b0;
      flush_ex_req  = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      imem_ready    = 1'b1;
      dmem_req      = 1'b0;
      dmem_ready    = 1'b1;
      halt_req      = 1'b0;
   endtask

   // Ends at a negedge with rst just released
   task automatic apply_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   // Reset then four normal fetches: all four stages valid
   task automatic fill();
      apply_reset(2);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      #1;
      checks++;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, redirect_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_enables got %b exp 000000",
                  {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, redirect_valid});
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid, halted} !== 5'b0) begin
         errors++;
         $display("FAIL reset_valids got %b exp 00000",
                  {if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid, halted});
      end
      checks++;
      if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, flush_count);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (pc_en !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_pc_en got %b exp 1", pc_en);
      end
      @(negedge clk);
      checks++;
      if ({if_id_valid, id_ex_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_first_fetch got %b exp 10", {if_id_valid, id_ex_valid});
      end
   endtask

   task automatic test_load_use();
      fill();
      stall_id_req = 1'b1;
      flush_ex_req = 1'b1;
      #1;
      checks++;
      if ({pc_en, if_id_en, id_ex_en} !== 3'b001) begin
         errors++;
         $display("FAIL load_use_enables got %b exp 001", {pc_en, if_id_en, id_ex_en});
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if ({if_id_valid, id_ex_valid, ex_mem_valid} !== 3'b101) begin
         errors++;
         $display("FAIL load_use_valids got %b exp 101", {if_id_valid, id_ex_valid, ex_mem_valid});
      end
      checks++;
      if (stall_cycles !== 32'd1) begin
         errors++;
         $display("FAIL load_use_stall_cnt got %0d exp 1", stall_cycles);
      end
   endtask

   task automatic test_fetch_wait();
      fill();
      imem_ready = 1'b0;
      #1;
      checks++;
      if ({pc_en, if_id_en} !== 2'b01) begin
         errors++;
         $display("FAIL fetch_wait_enables got %b exp 01", {pc_en, if_id_en});
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if ({if_id_valid, id_ex_valid} !== 2'b01) begin
         errors++;
         $display("FAIL fetch_wait_valids got %b exp 01", {if_id_valid, id_ex_valid});
      end
   endtask

   task automatic test_branch(input logic with_stall);
      fill();
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0100;
      stall_id_req  = with_stall;
      #1;
      checks++;
      if ({redirect_valid, pc_en} !== 2'b11 || redirect_pc !== 32'h100) begin
         errors++;
         $display("FAIL branch_redirect[%0d] got %b pc %h exp 11 pc 00000100",
                  with_stall, {redirect_valid, pc_en}, redirect_pc);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if ({if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid} !== 4'b0011 ||
          flush_count !== 32'd1) begin
         errors++;
         $display("FAIL branch_flush[%0d] got %b cnt %0d exp 0011 cnt 1", with_stall,
                  {if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid}, flush_count);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({if_id_valid, id_ex_valid} !== 2'b11) begin
         errors++;
         $display("FAIL branch_target_arrival[%0d] got %b exp 11", with_stall,
                  {if_id_valid, id_ex_valid});
      end
   endtask

   task automatic test_mem_wait();
      fill();
      dmem_req      = 1'b1;
      dmem_ready    = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0200;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({redirect_valid, pc_en, ex_mem_en, mem_wb_en} !== 4'b0001) begin
            errors++;
            $display("FAIL mem_wait_enables[%0d] got %b exp 0001", i,
                     {redirect_valid, pc_en, ex_mem_en, mem_wb_en});
         end
         @(negedge clk);
         checks++;
         if ({ex_mem_valid, mem_wb_valid} !== 2'b10) begin
            errors++;
            $display("FAIL mem_wait_bubble[%0d] got %b exp 10", i, {ex_mem_valid, mem_wb_valid});
         end
      end
      checks++;
      if (stall_cycles !== 32'd4 || flush_count !== 32'd0) begin
         errors++;
         $display("FAIL mem_wait_counts got %0d/%0d exp 4/0", stall_cycles, flush_count);
      end
      dmem_ready = 1'b1;
      #1;
      checks++;
      if (redirect_valid !== 1'b1) begin
         errors++;
         $display("FAIL mem_wait_release_redirect got %b exp 1", redirect_valid);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (flush_count !== 32'd1 || stall_cycles !== 32'd4 ||
          {if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid} !== 4'b0011) begin
         errors++;
         $display("FAIL mem_wait_release got cnt %0d/%0d valids %b exp 4/1 0011",
                  stall_cycles, flush_count,
                  {if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid});
      end
   endtask

   task automatic test_halt();
      fill();
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      #1;
      checks++;
      if (pc_en !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_drain_entry got pc_en %b halted %b exp 0 0", pc_en, halted);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_early got %b exp 0", halted);
      end
      @(negedge clk);
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_reached got %b exp 1", halted);
      end
      branch_taken = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, redirect_valid, halted} !==
             7'b0000001) begin
            errors++;
            $display("FAIL halted_hold[%0d] got %b exp 0000001", i,
                     {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, redirect_valid, halted});
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_drain();
      fill();
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid, halted} !== 5'b0 ||
          stall_cycles !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_drain got %b cnt %0d exp 00000 cnt 0",
                  {if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid, halted}, stall_cycles);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (pc_en !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_drain_run got pc_en %b exp 1", pc_en);
      end
   endtask

   task automatic test_saturation();
      apply_reset(2);
      stall_if_req = 1'b1;
      repeat (20) @(negedge clk);
      idle_inputs();
      checks++;
      if (s_stall_cycles !== 4'd15) begin
         errors++;
         $display("FAIL sat_small got %0d exp 15", s_stall_cycles);
      end
      checks++;
      if (stall_cycles !== 32'd20) begin
         errors++;
         $display("FAIL sat_wide got %0d exp 20", stall_cycles);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_fetch_wait();
      test_branch(1'b0);
      test_branch(1'b1);
      test_mem_wait();
      test_halt();
      test_reset_mid_drain();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
